sram_oq_scheduler: RTL and testbench

- Memory-side command scheduler for the SRAM output queue.
- Takes per-word write requests, each tagged with a one-hot output queue. Tracks per-queue circular regions in SRAM: head, tail, commit pointers and word counts.
- Each cycle, arbitrates the single SRAM command slot between the write stream and round-robin reads of queues whose downstream port can accept data.
- Reads expose only packets that have been fully written, so forwarding is store-and-forward.

---
 rtl/sram_oq_scheduler_pkg.sv | 37 +++
 rtl/sram_oq_scheduler_rr_arbiter.sv | 38 +++
 rtl/sram_oq_scheduler.sv | 142 ++++++++++++++
 tb/tb_sram_oq_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_oq_scheduler_pkg.sv
// Shared constants, command payload and helpers for the SRAM output-queue scheduler.
package nf10_sram_oq_pkg;

  localparam int unsigned NUM_QUEUES     = 5;
  localparam int unsigned QUEUE_ID_WIDTH = 3;
  localparam int unsigned MEM_ADDR_WIDTH = 19;
  localparam int unsigned QUEUE_SIZE     = 104857;

  typedef logic [NUM_QUEUES-1:0][MEM_ADDR_WIDTH-1:0] base_table_t;

  typedef struct packed {
    logic                      we;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [QUEUE_ID_WIDTH-1:0] qid;
  } mem_cmd_t;

  // Per-queue region base addresses, folded to constants at elaboration.
  function automatic base_table_t make_base_table(input int unsigned qsize);
    base_table_t t;
    t = '0;
    for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
      t[q] = MEM_ADDR_WIDTH'(q * qsize);
    end
    return t;
  endfunction

  // Lowest set bit wins, so a multi-hot vector resolves deterministically.
  function automatic logic [QUEUE_ID_WIDTH-1:0] onehot_to_idx(input logic [NUM_QUEUES-1:0] oh);
    logic [QUEUE_ID_WIDTH-1:0] idx;
    idx = '0;
    for (int q = NUM_QUEUES - 1; q >= 0; q--) begin
      if (oh[q]) idx = QUEUE_ID_WIDTH'(q);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sram_oq_scheduler_rr_arbiter.sv
// Round-robin read picker: first eligible queue strictly after the last one served.
module sram_oq_rr_arbiter
  import nf10_sram_oq_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_QUEUES-1:0]     elig,
  input  logic                      advance,
  output logic                      any_c,
  output logic [QUEUE_ID_WIDTH-1:0] pick_c
);

  logic [QUEUE_ID_WIDTH-1:0] last;
  int unsigned               cand;

  always_comb begin
    any_c  = 1'b0;
    pick_c = '0;
    cand   = 0;
    for (int unsigned k = 1; k <= NUM_QUEUES; k++) begin
      cand = 32'(last) + k;
      if (cand >= NUM_QUEUES) cand = cand - NUM_QUEUES;
      if (!any_c && elig[QUEUE_ID_WIDTH'(cand)]) begin
        any_c  = 1'b1;
        pick_c = QUEUE_ID_WIDTH'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= '0;
    end else if (advance) begin
      last <= pick_c;
    end
  end

endmodule

// File: rtl/sram_oq_scheduler.sv
// Arbitrates the single SRAM command slot between queued writes and round-robin
// reads of fully committed packets across the per-queue circular regions.
module sram_oq_scheduler
  import nf10_sram_oq_pkg::*;
#(
  parameter int unsigned QUEUE_SIZE = nf10_sram_oq_pkg::QUEUE_SIZE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_req,
  input  logic [NUM_QUEUES-1:0]     wr_oq,
  input  logic                      wr_last,
  output logic                      wr_grant,
  input  logic [NUM_QUEUES-1:0]     rd_ready,
  output logic                      mem_cmd_valid,
  output logic                      mem_cmd_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_cmd_addr,
  output logic [QUEUE_ID_WIDTH-1:0] mem_cmd_qid,
  input  logic                      mem_cmd_ready,
  output logic [NUM_QUEUES-1:0]     q_empty,
  output logic [NUM_QUEUES-1:0]     q_full,
  output logic                      err_oq
);

  localparam int unsigned OFF_WIDTH = $clog2(QUEUE_SIZE);
  localparam int unsigned CNT_WIDTH = $clog2(QUEUE_SIZE + 1);
  localparam logic [OFF_WIDTH-1:0] OFF_MAX = OFF_WIDTH'(QUEUE_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(QUEUE_SIZE);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam base_table_t          BASE    = make_base_table(QUEUE_SIZE);

  logic [OFF_WIDTH-1:0] head          [NUM_QUEUES];
  logic [OFF_WIDTH-1:0] tail          [NUM_QUEUES];
  logic [CNT_WIDTH-1:0] used          [NUM_QUEUES];
  logic [CNT_WIDTH-1:0] committed     [NUM_QUEUES];
  logic [OFF_WIDTH-1:0] head_nxt      [NUM_QUEUES];
  logic [OFF_WIDTH-1:0] tail_nxt      [NUM_QUEUES];
  logic [CNT_WIDTH-1:0] used_nxt      [NUM_QUEUES];
  logic [CNT_WIDTH-1:0] committed_nxt [NUM_QUEUES];

  mem_cmd_t                  cmd;
  mem_cmd_t                  cmd_nxt;
  logic                      cmd_valid;
  logic                      prio_rd;
  logic                      slot_free;
  logic [QUEUE_ID_WIDTH-1:0] wr_sel;
  logic                      wr_elig;
  logic [NUM_QUEUES-1:0]     rd_elig;
  logic                      rd_any;
  logic [QUEUE_ID_WIDTH-1:0] rd_pick;
  logic                      wr_win;
  logic                      rd_win;

  function automatic logic [OFF_WIDTH-1:0] next_off(input logic [OFF_WIDTH-1:0] off);
    return (off == OFF_MAX) ? '0 : off + OFF_WIDTH'(1);
  endfunction

  // Eligibility and slot arbitration; prio_rd=0 favours the write stream on contention.
  always_comb begin
    slot_free = !cmd_valid || mem_cmd_ready;
    wr_sel    = onehot_to_idx(wr_oq);
    wr_elig   = wr_req && (wr_oq != '0) && !q_full[wr_sel];
    for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
      rd_elig[q] = (committed[q] != '0) && rd_ready[q];
    end
    wr_win = slot_free && wr_elig && (!rd_any || !prio_rd);
    rd_win = slot_free && rd_any && (!wr_elig || prio_rd);
  end

  assign wr_grant = wr_win;

  sram_oq_rr_arbiter u_rr (
    .clk     (clk),
    .reset   (reset),
    .elig    (rd_elig),
    .advance (rd_win),
    .any_c   (rd_any),
    .pick_c  (rd_pick)
  );

  // Next pointer/count state; a write with wr_last commits every word written so far.
  always_comb begin
    cmd_nxt = cmd;
    if (wr_win) begin
      cmd_nxt = '{we: 1'b1, addr: BASE[wr_sel] + MEM_ADDR_WIDTH'(tail[wr_sel]), qid: wr_sel};
    end else if (rd_win) begin
      cmd_nxt = '{we: 1'b0, addr: BASE[rd_pick] + MEM_ADDR_WIDTH'(head[rd_pick]), qid: rd_pick};
    end
    for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
      head_nxt[q]      = head[q];
      tail_nxt[q]      = tail[q];
      used_nxt[q]      = used[q];
      committed_nxt[q] = committed[q];
      if (wr_win && wr_sel == QUEUE_ID_WIDTH'(q)) begin
        tail_nxt[q] = next_off(tail[q]);
        used_nxt[q] = used[q] + CNT_ONE;
        if (wr_last) committed_nxt[q] = used[q] + CNT_ONE;
      end
      if (rd_win && rd_pick == QUEUE_ID_WIDTH'(q)) begin
        head_nxt[q]      = next_off(head[q]);
        used_nxt[q]      = used[q] - CNT_ONE;
        committed_nxt[q] = committed[q] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd       <= '0;
      cmd_valid <= 1'b0;
      prio_rd   <= 1'b0;
      err_oq    <= 1'b0;
      q_empty   <= '1;
      q_full    <= '0;
      for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
        head[q]      <= '0;
        tail[q]      <= '0;
        used[q]      <= '0;
        committed[q] <= '0;
      end
    end else begin
      if (slot_free) cmd_valid <= wr_win || rd_win;
      cmd <= cmd_nxt;
      if (slot_free && wr_elig && rd_any) prio_rd <= !prio_rd;
      if (wr_req && wr_oq == '0) err_oq <= 1'b1;
      for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
        head[q]      <= head_nxt[q];
        tail[q]      <= tail_nxt[q];
        used[q]      <= used_nxt[q];
        committed[q] <= committed_nxt[q];
        q_empty[q]   <= (committed_nxt[q] == '0);
        q_full[q]    <= (used_nxt[q] == CNT_MAX);
      end
    end
  end

  assign mem_cmd_valid = cmd_valid;
  assign mem_cmd_we    = cmd.we;
  assign mem_cmd_addr  = cmd.addr;
  assign mem_cmd_qid   = cmd.qid;

endmodule

// File: tb/tb_sram_oq_scheduler.sv
// Scoreboard bench for sram_oq_scheduler with QUEUE_SIZE=4 (bases 0,4,8,12,16).
module tb_sram_oq_scheduler;
  import nf10_sram_oq_pkg::*;

  logic                      clk;
  logic                      reset;
  logic                      wr_req;
  logic [NUM_QUEUES-1:0]     wr_oq;
  logic                      wr_last;
  logic                      wr_grant;
  logic [NUM_QUEUES-1:0]     rd_ready;
  logic                      mem_cmd_valid;
  logic                      mem_cmd_we;
  logic [MEM_ADDR_WIDTH-1:0] mem_cmd_addr;
  logic [QUEUE_ID_WIDTH-1:0] mem_cmd_qid;
  logic                      mem_cmd_ready;
  logic [NUM_QUEUES-1:0]     q_empty;
  logic [NUM_QUEUES-1:0]     q_full;
  logic                      err_oq;

  int errors = 0;
  int checks = 0;
  mem_cmd_t exp_q[$];
  mem_cmd_t exp_e;

  sram_oq_scheduler #(.QUEUE_SIZE(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_req        (wr_req),
    .wr_oq         (wr_oq),
    .wr_last       (wr_last),
    .wr_grant      (wr_grant),
    .rd_ready      (rd_ready),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_we    (mem_cmd_we),
    .mem_cmd_addr  (mem_cmd_addr),
    .mem_cmd_qid   (mem_cmd_qid),
    .mem_cmd_ready (mem_cmd_ready),
    .q_empty       (q_empty),
    .q_full        (q_full),
    .err_oq        (err_oq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_cmd(input logic we, input int addr, input int qid);
    mem_cmd_t c;
    c.we   = we;
    c.addr = MEM_ADDR_WIDTH'(addr);
    c.qid  = QUEUE_ID_WIDTH'(qid);
    exp_q.push_back(c);
  endtask

  // Monitor: every command accepted by the SRAM side must match the queue head.
  always @(negedge clk) begin
    if (!reset && mem_cmd_valid && mem_cmd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmd: got we=%0b addr=%0d qid=%0d expected none",
                 mem_cmd_we, mem_cmd_addr, mem_cmd_qid);
      end else begin
        exp_e = exp_q.pop_front();
        if (mem_cmd_we !== exp_e.we || mem_cmd_addr !== exp_e.addr || mem_cmd_qid !== exp_e.qid) begin
          errors++;
          $display("FAIL cmd: got we=%0b addr=%0d qid=%0d expected we=%0b addr=%0d qid=%0d",
                   mem_cmd_we, mem_cmd_addr, mem_cmd_qid, exp_e.we, exp_e.addr, exp_e.qid);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_grant(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!wr_grant && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!wr_grant) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no wr_grant expected wr_grant=1 within 50 cycles", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_words(input logic [NUM_QUEUES-1:0] oq, input int n, input logic last_at_end);
    for (int i = 0; i < n; i++) begin
      wr_req  = 1'b1;
      wr_oq   = oq;
      wr_last = last_at_end && (i == n - 1);
      wait_grant("write");
    end
    wr_req  = 1'b0;
    wr_oq   = '0;
    wr_last = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      cycles(1);
      t++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    cycles(3);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_valid"}, 32'(mem_cmd_valid), 32'd0);
    check({name, "_we"},    32'(mem_cmd_we),    32'd0);
    check({name, "_addr"},  32'(mem_cmd_addr),  32'd0);
    check({name, "_qid"},   32'(mem_cmd_qid),   32'd0);
    check({name, "_empty"}, 32'(q_empty),       32'h1f);
    check({name, "_full"},  32'(q_full),        32'd0);
    check({name, "_err"},   32'(err_oq),        32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; wr_req = 1'b0; wr_oq = '0; wr_last = 1'b0;
    rd_ready = '0; mem_cmd_ready = 1'b1;
    cycles(2);
    check_reset_values("reset");
    reset = 1'b0;
    cycles(1);

    // Store-and-forward through queue 2
    rd_ready = 5'h1f;
    expect_cmd(1, 8, 2); expect_cmd(1, 9, 2); expect_cmd(1, 10, 2);
    expect_cmd(0, 8, 2); expect_cmd(0, 9, 2); expect_cmd(0, 10, 2);
    send_words(5'b00100, 3, 1'b1);
    check("q2_empty_after_commit", 32'(q_empty[2]), 32'd0);
    drain("q2");
    check("q2_empty_after_reads", 32'(q_empty[2]), 32'd1);

    // Uncommitted words in queue 1 must not be read
    expect_cmd(1, 4, 1); expect_cmd(1, 5, 1);
    send_words(5'b00010, 2, 1'b0);
    cycles(8);
    check("q1_no_read_uncommitted", 32'(mem_cmd_valid), 32'd0);
    check("q1_empty_uncommitted", 32'(q_empty[1]), 32'd1);
    expect_cmd(1, 6, 1);
    expect_cmd(0, 4, 1); expect_cmd(0, 5, 1); expect_cmd(0, 6, 1);
    send_words(5'b00010, 1, 1'b1);
    drain("q1");

    // Fill queue 0, stall a fifth word, then free one slot (wrap to addr 0)
    rd_ready = 5'b11110;
    expect_cmd(1, 0, 0); expect_cmd(1, 1, 0); expect_cmd(1, 2, 0); expect_cmd(1, 3, 0);
    send_words(5'b00001, 4, 1'b1);
    check("q0_full", 32'(q_full[0]), 32'd1);
    expect_cmd(0, 0, 0); expect_cmd(1, 0, 0);
    expect_cmd(0, 1, 0); expect_cmd(0, 2, 0); expect_cmd(0, 3, 0); expect_cmd(0, 0, 0);
    wr_req = 1'b1; wr_oq = 5'b00001; wr_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("full_stall_grant", 32'(wr_grant), 32'd0);
      @(posedge clk);
      #1;
    end
    rd_ready = 5'h1f;
    wait_grant("wrap_write");
    wr_req = 1'b0; wr_oq = '0; wr_last = 1'b0;
    drain("q0_wrap");

    // Clean reset, then park the round-robin pointer on queue 4
    reset = 1'b1;
    cycles(1);
    check_reset_values("reset2");
    reset = 1'b0;
    rd_ready = 5'b10000;
    expect_cmd(1, 16, 4); expect_cmd(0, 16, 4);
    send_words(5'b10000, 1, 1'b1);
    drain("q4_prime");

    // Load queues 0, 3, 4 with one committed word each while reads are blocked
    rd_ready = '0;
    expect_cmd(1, 0, 0); expect_cmd(1, 12, 3); expect_cmd(1, 17, 4);
    send_words(5'b00001, 1, 1'b1);
    send_words(5'b01000, 1, 1'b1);
    send_words(5'b10000, 1, 1'b1);
    drain("load");

    // Write stream against three readable queues: W, R0, W, R3, W, R4
    expect_cmd(1, 4, 1); expect_cmd(0, 0, 0);
    expect_cmd(1, 5, 1); expect_cmd(0, 12, 3);
    expect_cmd(1, 6, 1); expect_cmd(0, 17, 4);
    rd_ready = 5'h1f;
    send_words(5'b00010, 3, 1'b0);
    drain("alternate");

    // Backpressure: command held stable while mem_cmd_ready is low
    mem_cmd_ready = 1'b0;
    expect_cmd(1, 8, 2); expect_cmd(0, 8, 2); expect_cmd(1, 9, 2);
    send_words(5'b00100, 1, 1'b1);
    wr_req = 1'b1; wr_oq = 5'b00100; wr_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(mem_cmd_valid), 32'd1);
      check("hold_addr",  32'(mem_cmd_addr),  32'd8);
      check("hold_qid",   32'(mem_cmd_qid),   32'd2);
      check("hold_grant", 32'(wr_grant),      32'd0);
      @(posedge clk);
      #1;
    end
    mem_cmd_ready = 1'b1;
    wait_grant("after_hold");
    wr_req = 1'b0; wr_oq = '0;
    drain("hold");

    // Request with no destination queue
    wr_req = 1'b1; wr_oq = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_oq_grant", 32'(wr_grant), 32'd0);
      @(posedge clk);
      #1;
    end
    wr_req = 1'b0;
    cycles(4);
    check("err_oq_sticky", 32'(err_oq), 32'd1);
    check("no_oq_no_cmd", 32'(mem_cmd_valid), 32'd0);

    // Reset while a command is pending
    mem_cmd_ready = 1'b0;
    send_words(5'b00001, 1, 1'b1);
    check("pending_before_reset", 32'(mem_cmd_valid), 32'd1);
    reset = 1'b1;
    cycles(1);
    check_reset_values("midreset");
    reset = 1'b0;
    mem_cmd_ready = 1'b1;
    cycles(4);
    check("post_reset_idle", 32'(mem_cmd_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
